// File: rtl/dmem_bridge.sv
// Bridges the core data-memory port onto a 32-bit word SRAM. Accesses that
// cross a word boundary are issued as two beats and merged on the way back.
module dmem_bridge #(
  parameter int SRAM_AW = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_i,
  input  logic               rw_i,
  input  logic [2:0]         ctrl_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               stall_o,
  output logic [31:0]        rdata_o,
  output logic               rdata_valid_o,
  output logic               sram_cs_o,
  output logic               sram_we_o,
  output logic [3:0]         sram_be_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  // Low nibble holds the first-beat lanes, high nibble the second-beat lanes.
  function automatic logic [7:0] lane_mask(input logic [2:0] ctrl, input logic [1:0] off);
    logic [7:0] base;
    case (ctrl[1:0])
      2'b00:   base = 8'b0000_0001;
      2'b01:   base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  logic [0:0]         state;
  logic [SRAM_AW-1:0] addr_q;
  logic [2:0]         ctrl_q;
  logic [1:0]         off_q;
  logic               rw_q;
  logic [31:0]        wdata_q;
  logic [31:0]        hold_q;
  logic               resp_pend;
  logic [1:0]         resp_off;
  logic [2:0]         resp_ctrl;
  logic               resp_split;

  logic       valid_in;
  logic       accept;
  logic [7:0] mask_in;
  logic [7:0] mask_q;
  logic       split_in;

  assign valid_in = ctrl_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign accept   = (state == IDLE) && req_i && valid_in;
  assign mask_in  = lane_mask(ctrl_i, addr_i[1:0]);
  assign mask_q   = lane_mask(ctrl_q, off_q);
  assign split_in = |mask_in[7:4];

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 4'b0000;
    sram_addr_o  = '0;
    sram_wdata_o = 32'h0;
    stall_o      = 1'b0;
    if (!reset) begin
      if (state == SECOND) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = rw_q;
        sram_be_o    = mask_q[7:4];
        sram_addr_o  = addr_q + SRAM_AW'(1);
        sram_wdata_o = wdata_q >> {(3'd4 - {1'b0, off_q}), 3'b000};
      end else if (accept) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = rw_i;
        sram_be_o    = mask_in[3:0];
        sram_addr_o  = addr_i[SRAM_AW+1:2];
        sram_wdata_o = wdata_i << {addr_i[1:0], 3'b000};
        stall_o      = split_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      ctrl_q     <= 3'b000;
      off_q      <= 2'b00;
      rw_q       <= 1'b0;
      wdata_q    <= 32'h0;
      hold_q     <= 32'h0;
      resp_pend  <= 1'b0;
      resp_off   <= 2'b00;
      resp_ctrl  <= 3'b000;
      resp_split <= 1'b0;
    end else begin
      resp_pend <= 1'b0;
      if (state == SECOND) begin
        state <= IDLE;
        if (!rw_q) begin
          hold_q     <= sram_rdata_i;
          resp_pend  <= 1'b1;
          resp_off   <= off_q;
          resp_ctrl  <= ctrl_q;
          resp_split <= 1'b1;
        end
      end else if (accept) begin
        if (split_in) begin
          state   <= SECOND;
          addr_q  <= addr_i[SRAM_AW+1:2];
          ctrl_q  <= ctrl_i;
          off_q   <= addr_i[1:0];
          rw_q    <= rw_i;
          wdata_q <= wdata_i;
        end else if (!rw_i) begin
          resp_pend  <= 1'b1;
          resp_off   <= addr_i[1:0];
          resp_ctrl  <= ctrl_i;
          resp_split <= 1'b0;
        end
      end
    end
  end

  // Split loads see first-beat bytes in hold_q and second-beat bytes live on the bus.
  logic [63:0] merged;
  logic [31:0] sel;
  assign merged = resp_split ? {sram_rdata_i, hold_q} : {32'h0, sram_rdata_i};
  assign sel    = 32'(merged >> {resp_off, 3'b000});

  assign rdata_valid_o = resp_pend;

  always_comb begin
    rdata_o = 32'h0;
    if (resp_pend) begin
      case (resp_ctrl)
        3'b000:  rdata_o = {{24{sel[7]}}, sel[7:0]};
        3'b001:  rdata_o = {{16{sel[15]}}, sel[15:0]};
        3'b100:  rdata_o = {24'h0, sel[7:0]};
        3'b101:  rdata_o = {16'h0, sel[15:0]};
        default: rdata_o = sel;
      endcase
    end
  end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter SRAM_AW, default 30, SRAM word-address width; the word address is addr_i[SRAM_AW+1:2].
REQ-002 clk  in  1  rising-edge clock; one clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_i  in  1  core issues a data-memory access this cycle.
REQ-005 rw_i  in  1  1 = store, 0 = load.
REQ-006 ctrl_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are invalid.
REQ-007 addr_i  in  32  byte address.
REQ-008 wdata_i  in  32  store data, right-aligned.
REQ-009 stall_o  out  1  core must hold its request in the next cycle.
REQ-010 rdata_o  out  32  extended load result.
REQ-011 rdata_valid_o  out  1  rdata_o is valid this cycle.
REQ-012 sram_cs_o  out  1  SRAM access strobe.
REQ-013 sram_we_o  out  1  SRAM write.
REQ-014 sram_be_o  out  4  byte-lane enables; lane k = bits [8k+7:8k].
REQ-015 sram_addr_o  out  SRAM_AW  SRAM word address.
REQ-016 sram_wdata_o  out  32  lane-aligned write data.
REQ-017 sram_rdata_i  in  32  SRAM read data, valid the cycle after a read strobe.

Function
REQ-018 SHALL use FSM states IDLE and SECOND.
- Size: 1 for B/BU, 2 for H/HU, 4 for W.
- off = addr_i[1:0].
REQ-019 SHALL classify an access as split when off + size > 4.
- A split access occurs for H at off 3, and for W at off 1, 2 or 3.
REQ-020 SHALL, in IDLE with req_i=1 and a valid ctrl_i, drive the first beat combinationally in the same cycle:
- cs=1, we=rw_i, addr = word(addr_i);
- be = lanes off through min(off+size-1, 3);
- wdata = wdata_i << 8*off.
REQ-021 SHALL, for a non-split access, remain in IDLE with stall_o=0.
REQ-022 SHALL, for a split access, assert stall_o=1 combinationally in the first-beat cycle and register addr, ctrl, rw and wdata; the next state is SECOND.
REQ-023 SHALL, in SECOND, ignore all core inputs and drive the second beat from the registered values:
- cs=1, addr = word+1 (wrapping modulo 2^SRAM_AW);
- be = lanes 0 through off+size-5;
- wdata = wdata >> 8*(4-off).
REQ-024 SHALL drive stall_o=0 in SECOND and return to IDLE after one cycle.
REQ-025 SHALL, for an invalid ctrl_i or req_i=0 in IDLE, drive cs=0, be=0, stall_o=0 and produce no response.
REQ-026 SHALL keep sram_be_o=0, sram_we_o=0 and sram_wdata_o=0 whenever cs=0.
REQ-027 SHALL register the response context (off, ctrl, split) for every load beat that completes the access.
REQ-028 SHALL, for a non-split load, assert rdata_valid_o exactly 1 cycle after the request cycle.
REQ-029 SHALL, for a split load, capture first-beat sram_rdata_i into a holding register during SECOND.
REQ-030 SHALL, for a split load, merge the holding register and second-beat data and assert rdata_valid_o exactly 2 cycles after the first-beat cycle.
REQ-031 SHALL form rdata_o from the selected bytes as follows:
- sign-extend for B/H;
- zero-extend for BU/HU;
- drive 0 whenever rdata_valid_o=0.
REQ-032 SHALL never assert rdata_valid_o for stores.
REQ-033 SHALL accept a new request in the cycle after SECOND.
- The new request's first beat may coincide with the previous split load's response cycle.
- Both SHALL complete correctly with no extra stall.

Reset
REQ-034 SHALL, while reset=1 asynchronously, force the following:
- state IDLE;
- all context, holding and wdata registers to 0;
- stall_o=0, rdata_valid_o=0, rdata_o=0;
- sram_cs_o=0, sram_we_o=0, sram_be_o=0.
REQ-035 SHALL, on reset asserted in SECOND or with a load response pending, abandon the access: no second beat and no rdata_valid_o after reset release.
REQ-036 SHALL accept a request in the first clock cycle after reset deassertion.

Verification
REQ-037 SW addr 0x100, wdata 0xDEADBEEF -> cs=1, we=1, be=1111, sram_addr 0x40, stall_o=0, no rdata_valid_o.
REQ-038 LB addr 0x103, SRAM word 0x80112233 -> next cycle rdata_valid_o=1, rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH addr 0x203, wdata 0x0000A1B2 ->
- beat 1: be=1000, wdata 0xB2000000, addr 0x80, stall_o=1;
- beat 2: be=0001, wdata 0x000000A1, addr 0x81.
REQ-040 LW addr 0x301, words 0x44332211 @0xC0 and 0x88776655 @0xC1 -> rdata_o=0x55443322 two cycles after beat 1, stall_o high for one cycle only.
REQ-041 Split LW at addr 0xFFFFFFFE -> second beat sram_addr wraps to 0x0.
REQ-042 Split LW followed by an LB accepted in the cycle after SECOND -> both responses correct in consecutive cycles.
REQ-043 Reset asserted during SECOND of a split SW -> no second-beat strobe, outputs at reset values, next request served normally.
